// File: rtl/uart_arb_pkg.sv
// Shared types and timing helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_e;

    localparam int DEF_BUSY_TO = 16;

    // Clock cycles per UART bit; integer divide, matching the receive path.
    function automatic int bit_cyc(input int rx_clk, input int bd_rate);
        return rx_clk / bd_rate;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin select: first valid index after ptr, wrapping.
module uart_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    int idx;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = 0;
        // Scan farthest offset first so the nearest valid index is the last write.
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (valid[idx]) begin
                winner = IW'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter among NUM_REQ producers.
// Optional packet lock (req_last port) enabled by defining UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int BD_RATE  = 9600,
    parameter  int RX_CLK   = 50_000_000,
    parameter  int GAP_BITS = 1,
    parameter  int BUSY_TO  = DEF_BUSY_TO,
    localparam int IW       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
`ifdef UART_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_last,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IW-1:0]        grant_id,
    output logic                 arb_busy,
    output logic                 err_nostart
);

    localparam int GAP_CYC = GAP_BITS * bit_cyc(RX_CLK, BD_RATE);
    localparam int CNT_MAX = (GAP_CYC > BUSY_TO) ? GAP_CYC : BUSY_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    // With no gap configured, frame completion drops straight back to IDLE.
    localparam arb_state_e POST_FRAME = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

    arb_state_e           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [NUM_REQ-1:0]   ready_n;
    logic                 start_n;
    logic                 err_n;
    logic [7:0]           data_n;
    logic [IW-1:0]        grant_n;
    logic [NUM_REQ-1:0]   pick_valid;
    logic [IW-1:0]        pick_id;
    logic                 pick_any;

`ifdef UART_ARB_PKT_LOCK_EN
    logic                 locked, locked_n;
    logic [IW-1:0]        lock_id, lock_id_n;

    // While locked only the owning requester is visible to the picker.
    always_comb begin
        pick_valid = req_valid;
        if (locked) pick_valid = req_valid & (NUM_REQ'(1) << lock_id);
    end
`else
    always_comb pick_valid = req_valid;
`endif

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid  (pick_valid),
        .ptr    (ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    assign arb_busy = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        grant_n = grant_id;
        data_n  = tx_data;
        ready_n = '0;
        start_n = 1'b0;
        err_n   = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
        locked_n  = locked;
        lock_id_n = lock_id;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_any && !tx_busy) begin
                    ready_n[pick_id] = 1'b1;
                    start_n          = 1'b1;
                    data_n           = req_data[8*int'(pick_id) +: 8];
                    grant_n          = pick_id;
                    ptr_n            = pick_id;
                    cnt_n            = '0;
                    state_n          = ST_WAIT_BUSY;
`ifdef UART_ARB_PKT_LOCK_EN
                    locked_n  = ~req_last[pick_id];
                    lock_id_n = pick_id;
`endif
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = ST_WAIT_DONE;
                end else if (cnt == BUSY_LAST) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = POST_FRAME;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_n   = '0;
                    state_n = POST_FRAME;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_n = ST_IDLE;
                else                 cnt_n   = cnt + CNT_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ptr         <= IW'(NUM_REQ - 1);
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            err_nostart <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            locked      <= 1'b0;
            lock_id     <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            req_ready   <= ready_n;
            tx_start    <= start_n;
            tx_data     <= data_n;
            grant_id    <= grant_n;
            err_nostart <= err_n;
`ifdef UART_ARB_PKT_LOCK_EN
            locked      <= locked_n;
            lock_id     <= lock_id_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter, scaled to 16 clocks per bit.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int BD_RATE   = 10_000;
    localparam int RX_CLK    = 160_000;
    localparam int GAP_BITS  = 1;
    localparam int BUSY_TO   = 16;
    localparam int BUSY_DLY  = 2;
    localparam int FRAME_CYC = 160;
    // Grant-to-grant: 2 delay + 160 busy + 1 fall detect + 16 gap + 1 idle decide.
    localparam int GRANT_PERIOD = 180;
    // Busy-low observed to next req_ready: 16 gap + 1 idle + 1 launch cycle.
    localparam int GAP_TO_GRANT = 18;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [1:0]           grant_id;
    logic                 arb_busy;
    logic                 err_nostart;
`ifdef UART_ARB_PKT_LOCK_EN
    logic [NUM_REQ-1:0]   req_last;
`endif

    logic model_en   = 1'b0;
    logic model_busy = 1'b0;
    logic ext_busy   = 1'b0;
    assign tx_busy = model_busy | ext_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BD_RATE (BD_RATE),
        .RX_CLK  (RX_CLK),
        .GAP_BITS(GAP_BITS),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
`ifdef UART_ARB_PKT_LOCK_EN
        .req_last   (req_last),
`endif
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .err_nostart(err_nostart)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises BUSY_DLY cycles after tx_start, lasts one frame.
    initial forever begin
        @(posedge clk); #1;
        if (model_en && tx_start) begin
            repeat (BUSY_DLY) @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (FRAME_CYC) @(posedge clk);
            #1 model_busy = 1'b0;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < limit);
        check({tag, "_seen"}, 32'(|req_ready), 32'd1);
    endtask

    task automatic wait_level(input string tag, input logic lvl, input int limit);
        int n = 0;
        while (tx_busy !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy !== lvl) check(tag, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},    32'(req_ready),   32'd0);
        check({tag, "_start"},    32'(tx_start),    32'd0);
        check({tag, "_data"},     32'(tx_data),     32'd0);
        check({tag, "_grant"},    32'(grant_id),    32'd0);
        check({tag, "_arb_busy"}, 32'(arb_busy),    32'd0);
        check({tag, "_err"},      32'(err_nostart), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

        req_valid = '0;
        req_data  = '0;
`ifdef UART_ARB_PKT_LOCK_EN
        req_last  = '1;
`endif

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        rst = 1'b1;

        // Single requester: one-cycle latency, one-cycle pulses, then gap
        model_en       = 1'b1;
        req_data[7:0]  = 8'h55;
        req_valid      = 4'b0001;
        @(negedge clk);
        check("t1_ready",    32'(req_ready), 32'h1);
        check("t1_start",    32'(tx_start),  32'd1);
        check("t1_data",     32'(tx_data),   32'h55);
        check("t1_grant",    32'(grant_id),  32'd0);
        check("t1_arb_busy", 32'(arb_busy),  32'd1);
        req_valid = '0;
        @(negedge clk);
        check("t1_ready_pulse", 32'(req_ready), 32'd0);
        check("t1_start_pulse", 32'(tx_start),  32'd0);
        req_data[7:0] = 8'h66;
        req_valid     = 4'b0001;
        wait_level("t1_busy_rise", 1'b1, 50);
        wait_level("t1_busy_fall", 1'b0, 400);
        wait_ready("t1_next", 400, n);
        check("t1_gap_cycles", 32'(n),       32'(GAP_TO_GRANT));
        check("t1_next_data",  32'(tx_data), 32'h66);
        req_valid = '0;
        wait_level("t1_busy_rise2", 1'b1, 50);
        wait_level("t1_busy_fall2", 1'b0, 400);

        // Fairness with all requesters valid
        do_reset();
        req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ready($sformatf("t2_g%0d", g), 400, n);
            check($sformatf("t2_g%0d_period", g), 32'(n), (g == 0) ? 32'd1 : 32'(GRANT_PERIOD));
            check($sformatf("t2_g%0d_grant", g),  32'(grant_id),  32'(order[g]));
            check($sformatf("t2_g%0d_ready", g),  32'(req_ready), 32'(4'b0001 << order[g]));
            check($sformatf("t2_g%0d_data", g),   32'(tx_data),   32'(bytes[order[g]]));
        end
        req_valid = '0;
        wait_level("t2_busy_rise", 1'b1, 50);
        wait_level("t2_busy_fall", 1'b0, 400);

        // tx_busy never rises: timeout pulse after BUSY_TO, then gap, then IDLE
        model_en = 1'b0;
        do_reset();
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        @(negedge clk);
        check("t3_ready", 32'(req_ready), 32'h2);
        check("t3_grant", 32'(grant_id),  32'd1);
        check("t3_data",  32'(tx_data),   32'hA5);
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_nostart && n < 40);
        check("t3_err_delay", 32'(n), 32'(BUSY_TO));
        @(negedge clk);
        check("t3_err_pulse", 32'(err_nostart), 32'd0);
        check("t3_in_gap",    32'(arb_busy),    32'd1);
        repeat (14) @(negedge clk);
        check("t3_gap_end_minus1", 32'(arb_busy), 32'd1);
        @(negedge clk);
        check("t3_back_idle",      32'(arb_busy), 32'd0);

        // External busy blocks grants until released
        model_en        = 1'b1;
        ext_busy        = 1'b1;
        req_data[23:16] = 8'h3C;
        req_valid       = 4'b0100;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != '0) pulses++;
        end
        check("t4_no_grant_busy", 32'(pulses), 32'd0);
        ext_busy = 1'b0;
        @(negedge clk);
        check("t4_ready", 32'(req_ready), 32'h4);
        check("t4_grant", 32'(grant_id),  32'd2);
        check("t4_data",  32'(tx_data),   32'h3C);
        req_valid = '0;

        // Reset during WAIT_DONE drops everything; req0 wins afterwards
        wait_level("t5_busy_rise", 1'b1, 50);
        repeat (3) @(negedge clk);
        check("t5_wait_done", 32'(arb_busy), 32'd1);
        req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
        req_valid = 4'b1111;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_rst");
        rst = 1'b1;
        wait_ready("t5_after", 400, n);
        check("t5_grant", 32'(grant_id),  32'd0);
        check("t5_ready", 32'(req_ready), 32'h1);
        check("t5_data",  32'(tx_data),   32'h10);
        req_valid = '0;
        wait_level("t5_busy_rise2", 1'b1, 50);
        wait_level("t5_busy_fall2", 1'b0, 400);

`ifdef UART_ARB_PKT_LOCK_EN
        // Packet lock: req1 keeps the transmitter for three bytes despite req0
        do_reset();
        req_data  = '0;
        req_data[15:8] = 8'hC1;
        req_last  = 4'b0000;
        req_valid = 4'b0010;
        wait_ready("t6_b1", 400, n);
        check("t6_b1_grant", 32'(grant_id), 32'd1);
        check("t6_b1_data",  32'(tx_data),  32'hC1);
        req_data[7:0]  = 8'hB0;
        req_data[15:8] = 8'hC2;
        req_valid      = 4'b0011;
        wait_ready("t6_b2", 400, n);
        check("t6_b2_grant", 32'(grant_id), 32'd1);
        check("t6_b2_data",  32'(tx_data),  32'hC2);
        req_data[15:8] = 8'hC3;
        req_last       = 4'b0010;
        wait_ready("t6_b3", 400, n);
        check("t6_b3_grant", 32'(grant_id), 32'd1);
        check("t6_b3_data",  32'(tx_data),  32'hC3);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        wait_ready("t6_b4", 400, n);
        check("t6_b4_grant", 32'(grant_id), 32'd0);
        check("t6_b4_data",  32'(tx_data),  32'hB0);
        req_valid = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART byte transmitter among NUM_REQ byte producers. It accepts one byte per grant and launches it with a start/busy handshake to the transmitter. It tracks the transmitter's busy span, then enforces an inter-frame idle gap before the next grant. It sits between protocol/status producers and the serial TX block, using the same BD_RATE/RX_CLK timing parameters as the UART receive path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BD_RATE, 9600, UART baud rate in bits/s
RX_CLK, 50_000_000, clk frequency in Hz; BIT_CYC = RX_CLK/BD_RATE (integer divide, 5208 at defaults)
GAP_BITS, 1, idle bit-times inserted after each frame (0 = no gap)
BUSY_TO, 16, cycles allowed for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (rst=0 resets on rising clk edge)
req_valid  in  NUM_REQ  per-requester byte available; held until matching req_ready
req_data  in  NUM_REQ*8  packed bytes, requester i at [8*i+7:8*i]
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
tx_start  out  1  one-cycle launch pulse to transmitter
tx_data  out  8  byte to transmit; valid with tx_start, held until next launch
tx_busy  in  1  transmitter busy (frame in progress)
grant_id  out  $clog2(NUM_REQ)  index of last granted requester
arb_busy  out  1  high in any state other than IDLE
err_nostart  out  1  one-cycle pulse on BUSY_TO expiry

Behaviour:
- Reset (rst=0 at edge): state IDLE, rr pointer = NUM_REQ-1 (req0 wins first). All outputs 0. Any in-flight grant is dropped; no req_ready is issued for it.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req_valid=1 and tx_busy=0 at edge k, the winner is the first valid index scanning from ptr+1 mod NUM_REQ. At edge k+1, registered: req_ready[w]=1, tx_start=1, tx_data=req_data[w], grant_id=w, ptr=w, state WAIT_BUSY. Fixed latency: 1 cycle from sampled valid to launch. If tx_busy=1, remain in IDLE.
- req_ready and tx_start are high for exactly one cycle. A requester must not change req_data or drop req_valid before req_ready. It may reassert for the next byte the cycle after req_ready.
- WAIT_BUSY: on tx_busy=1, go to WAIT_DONE. After BUSY_TO cycles without tx_busy, pulse err_nostart and go to GAP.
- WAIT_DONE: on tx_busy=0, go to GAP.
- GAP: count GAP_BITS*BIT_CYC cycles, then go to IDLE. If GAP_BITS=0, go directly to IDLE. The counter width fits GAP_BITS*BIT_CYC; the counter clears on entry.
- Fairness: with all requesters valid, grants go 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 grants.
- A requester that drops valid (illegal) is simply not selected; the arbiter has no memory of the request.

Optional Feature:
UART_ARB_PKT_LOCK_EN. When defined, adds input req_last[NUM_REQ], sampled with the accepted byte. After a grant whose req_last=0, the arbiter locks to that requester. In IDLE it serves only that index, waiting indefinitely while the others are ignored. Lock releases after a byte with req_last=1 completes GAP; the rr pointer then advances normally. When undefined, there is no req_last port and arbitration is per byte.

Decomposition:
- Package uart_arb_pkg: state enum, function bit_cyc(RX_CLK, BD_RATE), default BUSY_TO.
- One sub-module, uart_rr_pick: combinational round-robin select taking (valid vector, ptr) and returning (winner index, any).

Test Plan:
- Reset then req_valid=4'b0001, data 0x55 → req_ready[0] and tx_start one cycle later, tx_data=0x55, grant_id=0. The next grant is no earlier than frame end + 5208 cycles.
- req_valid=4'b1111 held, model busy 2 cycles after start for 10*5208 cycles → grant order 0,1,2,3,0. Exactly one req_ready per frame.
- Model never raises tx_busy → err_nostart pulses 16 cycles after tx_start. Arbiter returns to IDLE after the gap.
- tx_busy=1 externally while req_valid=4'b0100 → no grant until tx_busy=0. Then grant_id=2.
- rst=0 asserted during WAIT_DONE → next edge all outputs 0, arb_busy=0. After release, req0 has priority again.
- With UART_ARB_PKT_LOCK_EN: req1 sends 3 bytes (last on byte 3) while req0 is valid → bytes go 1,1,1, then 0.
